// File: rtl/event_counter_pkg.sv
// event_counter_pkg: default sizing constants and saturation helper shared by the pulse-rate meter and its bench
package event_counter_pkg;
  localparam int GATE_CYCLES_DEF = 1000;
  localparam int GATE_WIDTH_DEF = 10;
  localparam int COUNT_WIDTH_DEF = 8;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction
  localparam int unsigned SAT_MAX_DEF = sat_max(COUNT_WIDTH_DEF);
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizes an async input and flags its edges; EVENT_COUNTER_BOTH_EDGES_EN selects rising+falling instead of rising only
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic det
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  // shift the async input through the synchronizer and remember the last synchronized value
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end
`ifdef EVENT_COUNTER_BOTH_EDGES_EN
  assign det = sync[SYNC_STAGES-1] ^ prev;
`else
  assign det = sync[SYNC_STAGES-1] & ~prev;
`endif
endmodule

// File: rtl/event_counter.sv
// event_counter: counts sig_in edges over a GATE_CYCLES window and hands the count out via valid/ready (EVENT_COUNTER_BOTH_EDGES_EN counts both edges)
module event_counter
  import event_counter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int GATE_WIDTH = GATE_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   result_sat,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun
);
  localparam logic [COUNT_WIDTH-1:0] MAX = COUNT_WIDTH'(sat_max(COUNT_WIDTH));
  logic det, term, accept, sat, sat_nxt;
  logic [GATE_WIDTH-1:0] gate;
  logic [COUNT_WIDTH-1:0] acc, acc_nxt;
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(sig_in),
    .det(det)
  );
  // saturating edge accumulation and end-of-window detection
  always_comb begin
    term = enable && (gate == GATE_WIDTH'(GATE_CYCLES - 1));
    acc_nxt = (det && acc != MAX) ? acc + COUNT_WIDTH'(1) : acc;
    sat_nxt = sat | (det && acc == MAX);
    accept = result_valid & result_ready;
  end
  // gate window: held clear while disabled, restarted after each terminal cycle
  always_ff @(posedge clk) begin
    if (rst || !enable || term) begin
      gate <= '0;
      acc <= '0;
      sat <= 1'b0;
    end else begin
      gate <= gate + GATE_WIDTH'(1);
      acc <= acc_nxt;
      sat <= sat_nxt;
    end
  end
  // result register with valid/ready handshake and sticky overrun on unread overwrite
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      result_sat <= 1'b0;
      result_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (term) begin
      result <= acc_nxt;
      result_sat <= sat_nxt;
      result_valid <= 1'b1;
      if (result_valid && !result_ready) overrun <= 1'b1;
    end else if (accept) begin
      result_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_event_counter.sv
// tb_event_counter: randomized and directed checks of two event_counter instances (10- and 40-cycle windows) against a window-count model
module tb_event_counter;
  import event_counter_pkg::*;
  localparam int S = 2;
  localparam int CW = 4;
  localparam int MAXV = int'(sat_max(CW));
`ifdef EVENT_COUNTER_BOTH_EDGES_EN
  localparam int BE = 2;
`else
  localparam int BE = 1;
`endif
  logic clk = 1'b0;
  logic rst, enable, sig_in;
  logic ready [2];
  logic [CW-1:0] res [2];
  logic sat [2], val [2], ovr [2];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  event_counter #(.GATE_CYCLES(10), .GATE_WIDTH(4), .COUNT_WIDTH(CW), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in), .result(res[0]), .result_sat(sat[0]),
    .result_valid(val[0]), .result_ready(ready[0]), .overrun(ovr[0])
  );
  event_counter #(.GATE_CYCLES(40), .GATE_WIDTH(6), .COUNT_WIDTH(CW), .SYNC_STAGES(S)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in), .result(res[1]), .result_sat(sat[1]),
    .result_valid(val[1]), .result_ready(ready[1]), .overrun(ovr[1])
  );
  // reference model: sampled input history, unbounded edge count per window, saturated only when reported
  logic [S:0] h = '0;
  int pos [2], cnt [2];
  logic [CW-1:0] e_res [2];
  logic e_sat [2], e_val [2], e_ovr [2];
  function automatic int glen(input int i);
    return i == 0 ? 10 : 40;
  endfunction
  always @(posedge clk) begin
    bit ev;
    int n;
    ev = (BE == 2) ? (h[S-1] ^ h[S]) : (h[S-1] & ~h[S]);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pos[i] = 0; cnt[i] = 0; e_res[i] = '0; e_sat[i] = 0; e_val[i] = 0; e_ovr[i] = 0;
      end else if (enable && pos[i] == glen(i) - 1) begin
        n = cnt[i] + int'(ev);
        e_res[i] = (n > MAXV) ? CW'(MAXV) : CW'(n);
        e_sat[i] = n > MAXV;
        if (e_val[i] && !ready[i]) e_ovr[i] = 1;
        e_val[i] = 1; pos[i] = 0; cnt[i] = 0;
      end else begin
        if (e_val[i] && ready[i]) e_val[i] = 0;
        if (enable) begin cnt[i] += int'(ev); pos[i]++; end
        else begin cnt[i] = 0; pos[i] = 0; end
      end
    end
    h = rst ? '0 : {h[S-1:0], sig_in};
  end
  task automatic tick(input logic s);
    sig_in = s;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1; enable = 0; sig_in = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1; enable = 1; ready = '{1'b0, 1'b0};
    tick(1);
    tick(0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({res[i], sat[i], val[i], ovr[i]} !== '0) begin
        miscompares++;
        $display("FAIL reset dut%0d: got res=%0d sat=%b val=%b ovr=%b, expected all 0", i, res[i], sat[i], val[i], ovr[i]);
      end
    end
  endtask
  task automatic test_rate();
    int pulses = 0;
    do_reset();
    enable = 1; ready = '{1'b1, 1'b1};
    for (int k = 1; k <= 80; k++) begin
      tick(k <= 40 ? logic'(k % 2) : logic'((k / 2) % 2));
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({res[i], sat[i], val[i], ovr[i]} !== {e_res[i], e_sat[i], e_val[i], e_ovr[i]}) begin
          miscompares++;
          $display("FAIL rate_model dut%0d k=%0d: got res=%0d sat=%b val=%b ovr=%b, expected res=%0d sat=%b val=%b ovr=%b", i, k, res[i], sat[i], val[i], ovr[i], e_res[i], e_sat[i], e_val[i], e_ovr[i]);
        end
      end
      if (k <= 40 && val[0]) pulses++;
      if (k >= 20 && k <= 40 && val[0]) begin
        vectors++;
        if ({res[0], sat[0]} !== {CW'(5 * BE), 1'b0}) begin
          miscompares++;
          $display("FAIL rate_toggle k=%0d: got res=%0d sat=%b, expected res=%0d sat=0", k, res[0], sat[0], 5 * BE);
        end
      end
      if (k >= 60 && val[0]) begin
        vectors++;
        if (BE == 2 ? (res[0] !== CW'(5)) : !(res[0] === CW'(2) || res[0] === CW'(3))) begin
          miscompares++;
          $display("FAIL rate_half k=%0d: got res=%0d, expected %s", k, res[0], BE == 2 ? "5" : "2 or 3");
        end
      end
    end
    vectors++;
    if (pulses !== 4) begin
      miscompares++;
      $display("FAIL rate_pulses: got %0d valid cycles in 40, expected 4", pulses);
    end
  endtask
  task automatic test_saturation();
    do_reset();
    enable = 1; ready = '{1'b1, 1'b1};
    for (int k = 1; k <= 120; k++) begin
      tick(k <= 78 ? logic'(k % 2) : logic'(k == 90 || k == 94 || k == 98));
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({res[i], sat[i], val[i], ovr[i]} !== {e_res[i], e_sat[i], e_val[i], e_ovr[i]}) begin
          miscompares++;
          $display("FAIL sat_model dut%0d k=%0d: got res=%0d sat=%b val=%b ovr=%b, expected res=%0d sat=%b val=%b ovr=%b", i, k, res[i], sat[i], val[i], ovr[i], e_res[i], e_sat[i], e_val[i], e_ovr[i]);
        end
      end
      if (k == 40 || k == 80) begin
        vectors++;
        if ({res[1], sat[1], val[1]} !== {CW'(15), 1'b1, 1'b1}) begin
          miscompares++;
          $display("FAIL sat_full k=%0d: got res=%0d sat=%b val=%b, expected res=15 sat=1 val=1", k, res[1], sat[1], val[1]);
        end
      end
      if (k == 120) begin
        vectors++;
        if ({res[1], sat[1], val[1]} !== {CW'(3 * BE), 1'b0, 1'b1}) begin
          miscompares++;
          $display("FAIL sat_clear: got res=%0d sat=%b val=%b, expected res=%0d sat=0 val=1", res[1], sat[1], val[1], 3 * BE);
        end
      end
    end
  endtask
  task automatic test_overrun();
    do_reset();
    enable = 1; ready = '{1'b1, 1'b0};
    for (int k = 1; k <= 80; k++) begin
      tick(logic'(k inside {5, 10, 15, 20, 45, 50, 55, 60, 65, 70}));
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({res[i], sat[i], val[i], ovr[i]} !== {e_res[i], e_sat[i], e_val[i], e_ovr[i]}) begin
          miscompares++;
          $display("FAIL ovr_model dut%0d k=%0d: got res=%0d sat=%b val=%b ovr=%b, expected res=%0d sat=%b val=%b ovr=%b", i, k, res[i], sat[i], val[i], ovr[i], e_res[i], e_sat[i], e_val[i], e_ovr[i]);
        end
      end
      if (k == 40) begin
        vectors++;
        if ({res[1], val[1], ovr[1]} !== {CW'(4 * BE), 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL ovr_first: got res=%0d val=%b ovr=%b, expected res=%0d val=1 ovr=0", res[1], val[1], ovr[1], 4 * BE);
        end
      end
    end
    vectors++;
    if ({res[1], val[1], ovr[1]} !== {CW'(6 * BE), 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL ovr_second: got res=%0d val=%b ovr=%b, expected res=%0d val=1 ovr=1", res[1], val[1], ovr[1], 6 * BE);
    end
    ready[1] = 1;
    tick(0);
    ready[1] = 0;
    vectors++;
    if ({val[1], ovr[1]} !== 2'b01) begin
      miscompares++;
      $display("FAIL ovr_accept: got val=%b ovr=%b, expected val=0 ovr=1", val[1], ovr[1]);
    end
  endtask
  task automatic test_latency();
    for (int d = 0; d < 2; d++) begin
      do_reset();
      enable = 1; ready = '{1'b1, 1'b1};
      for (int k = 1; k <= 20; k++) begin
        tick(logic'(k >= 8 + d));
        vectors++;
        if ({res[0], sat[0], val[0], ovr[0]} !== {e_res[0], e_sat[0], e_val[0], e_ovr[0]}) begin
          miscompares++;
          $display("FAIL lat_model d=%0d k=%0d: got res=%0d val=%b, expected res=%0d val=%b", d, k, res[0], val[0], e_res[0], e_val[0]);
        end
        if (k == 10 || k == 20) begin
          vectors++;
          if ({res[0], val[0]} !== {CW'((k == 10) == (d == 0)), 1'b1}) begin
            miscompares++;
            $display("FAIL latency d=%0d k=%0d: got res=%0d val=%b, expected res=%0d val=1", d, k, res[0], val[0], int'((k == 10) == (d == 0)));
          end
        end
      end
    end
  endtask
  task automatic test_enable();
    do_reset();
    ready = '{1'b1, 1'b1};
    for (int k = 1; k <= 25; k++) begin
      tick(logic'(k % 2));
      vectors++;
      if ({val[0], val[1]} !== 2'b00) begin
        miscompares++;
        $display("FAIL en_idle k=%0d: got val=%b%b, expected 00", k, val[0], val[1]);
      end
    end
    enable = 1;
    for (int k = 1; k <= 15; k++) begin
      rst = (k == 15);
      tick(logic'(k % 3 == 0));
      if (k <= 10) begin
        vectors++;
        if (val[0] !== (k == 10)) begin
          miscompares++;
          $display("FAIL en_first k=%0d: got val=%b, expected %b", k, val[0], k == 10);
        end
      end
    end
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({res[i], sat[i], val[i], ovr[i]} !== '0) begin
        miscompares++;
        $display("FAIL en_rst dut%0d: got res=%0d sat=%b val=%b ovr=%b, expected all 0", i, res[i], sat[i], val[i], ovr[i]);
      end
    end
    for (int k = 1; k <= 30; k++) begin
      enable = !(k >= 6 && k <= 8);
      tick(logic'(k % 2));
      vectors++;
      if ({res[0], sat[0], val[0], ovr[0]} !== {e_res[0], e_sat[0], e_val[0], e_ovr[0]}) begin
        miscompares++;
        $display("FAIL en_model k=%0d: got res=%0d val=%b, expected res=%0d val=%b", k, res[0], val[0], e_res[0], e_val[0]);
      end
      if (k <= 18) begin
        vectors++;
        if (val[0] !== (k == 18)) begin
          miscompares++;
          $display("FAIL en_restart k=%0d: got val=%b, expected %b", k, val[0], k == 18);
        end
      end
    end
  endtask
  task automatic test_random();
    do_reset();
    enable = 1;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      ready[0] = ($urandom_range(0, 1) == 1);
      ready[1] = ($urandom_range(0, 3) != 0);
      tick(logic'($urandom_range(0, 1)));
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({res[i], sat[i], val[i], ovr[i]} !== {e_res[i], e_sat[i], e_val[i], e_ovr[i]}) begin
          miscompares++;
          $display("FAIL random dut%0d k=%0d: got res=%0d sat=%b val=%b ovr=%b, expected res=%0d sat=%b val=%b ovr=%b", i, k, res[i], sat[i], val[i], ovr[i], e_res[i], e_sat[i], e_val[i], e_ovr[i]);
        end
      end
    end
    rst = 0;
  endtask
  initial begin
    rst = 1; enable = 0; sig_in = 0; ready = '{1'b0, 1'b0};
    @(negedge clk);
    test_reset();
    test_rate();
    test_saturation();
    test_overrun();
    test_latency();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
